// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide over WIDTH iterations, with a divide-by-zero short-cut and flush abort.
module pipe_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} stateT;
  stateT state, stateNext;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] accHi, accLo, dReg, hiReg, loReg;
  logic             divOp, dbzPend, negLo, negHi, dbzReg;

  logic             signedOp, aNeg, bNeg, isDiv, isZero, accept;
  logic [WIDTH-1:0] aMag, bMag;

  assign signedOp = SIGNED_EN && op[0];
  assign aNeg     = signedOp && a[WIDTH-1];
  assign bNeg     = signedOp && b[WIDTH-1];
  assign aMag     = aNeg ? -a : a;
  assign bMag     = bNeg ? -b : b;
  assign isDiv    = op[1];
  assign isZero   = isDiv && (b == '0);
  assign accept   = (state == IDLE) && start && !flush;

  // accHi/accLo hold the running product (multiply) or remainder/quotient (divide)
  logic [WIDTH:0] mulSum, mulPre, shifted, diff;
  logic           fits;

  assign mulSum  = {1'b0, accHi} + {1'b0, dReg};
  assign mulPre  = accLo[0] ? mulSum : {1'b0, accHi};
  assign shifted = {accHi, accLo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dReg};
  assign fits    = ~diff[WIDTH];

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   finHi, finLo;
  logic               finDbz;

  always_comb begin
    prod   = negLo ? -{accHi, accLo} : {accHi, accLo};
    finHi  = prod[2*WIDTH-1:WIDTH];
    finLo  = prod[WIDTH-1:0];
    finDbz = 1'b0;
    if (dbzPend) begin
      finHi  = accHi;
      finLo  = '1;
      finDbz = 1'b1;
    end else if (divOp) begin
      finHi = negHi ? -accHi : accHi;
      finLo = negLo ? -accLo : accLo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = isZero ? FIN : CALC;
      CALC: begin
        if (flush)                 stateNext = IDLE;
        else if (cnt == CW'(1))    stateNext = FIN;
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FIN presents the fixed-up result combinationally; the register write on the
  // FIN edge is suppressed by flush so HI/LO keep their old contents.
  assign busy        = (state != IDLE);
  assign done        = (state == FIN) && !flush;
  assign hi          = done ? finHi  : hiReg;
  assign lo          = done ? finLo  : loReg;
  assign div_by_zero = done ? finDbz : dbzReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      dReg    <= '0;
      divOp   <= 1'b0;
      dbzPend <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      dbzReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt     <= CW'(WIDTH);
          divOp   <= isDiv;
          dbzPend <= isZero;
          negLo   <= aNeg ^ bNeg;
          negHi   <= aNeg;
          dReg    <= isDiv ? bMag : aMag;
          accLo   <= isDiv ? aMag : bMag;
          accHi   <= isZero ? a : '0;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (divOp) begin
            accHi <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], fits};
          end else begin
            accHi <= mulPre[WIDTH:1];
            accLo <= {mulPre[0], accLo[WIDTH-1:1]};
          end
        end
        FIN: if (done) begin
          hiReg  <= finHi;
          loReg  <= finLo;
          dbzReg <= finDbz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_muldiv.sv
// Scoreboard bench for pipe_muldiv: three instances (32-bit signed, 32-bit
// unsigned-only, 8-bit signed) checked against an arithmetic reference model.
module tb_pipe_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // shared stimulus for the two 32-bit instances
  logic        rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busyA, doneA, dbzA, busyC, doneC, dbzC;
  logic [31:0] hiA, loA, hiC, loC;

  logic        rstB = 1'b0, startB = 1'b0, flushB = 1'b0;
  logic [1:0]  opB = 2'b00;
  logic [7:0]  aB = '0, bB = '0;
  logic        busyB, doneB, dbzB;
  logic [7:0]  hiB, loB;

  pipe_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) dutA (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busyA), .done(doneA), .hi(hiA), .lo(loA), .div_by_zero(dbzA));

  pipe_muldiv #(.WIDTH(32), .SIGNED_EN(1'b0)) dutC (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busyC), .done(doneC), .hi(hiC), .lo(loC), .div_by_zero(dbzC));

  pipe_muldiv #(.WIDTH(8), .SIGNED_EN(1'b1)) dutB (
    .clk(clk), .rst(rstB), .start(startB), .op(opB), .a(aB), .b(bB), .flush(flushB),
    .busy(busyB), .done(doneB), .hi(hiB), .lo(loB), .div_by_zero(dbzB));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned lat;
    int unsigned startCyc;
  } expT;

  expT qA[$], qC[$], qB[$];
  logic [31:0] lastHiA = '0, lastLoA = '0, lastHiC = '0, lastLoC = '0;
  logic        lastDbzA = 1'b0, lastDbzC = 1'b0;

  function automatic expT model(int unsigned w, bit sEn, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    expT e;
    longint unsigned mask = (64'd1 << w) - 1;
    longint sa = x;
    longint sb = y;
    longint unsigned ua, ub, p;
    longint q, r;
    bit sg = sEn && o[0];
    if (sg && x[w-1]) sa = sa - (longint'(1) << w);
    if (sg && y[w-1]) sb = sb - (longint'(1) << w);
    e.dbz = 1'b0;
    e.lat = w + 1;
    e.startCyc = 0;
    if (!o[1]) begin
      ua = sa;
      ub = sb;
      p = ua * ub;
      e.lo = 32'(p & mask);
      e.hi = 32'((p >> w) & mask);
    end else if ((longint'(y) & mask) == 0) begin
      e.hi  = x;
      e.lo  = 32'(mask);
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = 32'(q & mask);
      e.hi = 32'(r & mask);
    end
    return e;
  endfunction

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    expT e;
    if (doneA) begin
      if (qA.size() == 0) check("A.unexpectedDone", 1, 0);
      else begin
        e = qA.pop_front();
        check("A.hi", hiA, e.hi);
        check("A.lo", loA, e.lo);
        check("A.dbz", dbzA, e.dbz);
        check("A.latency", cyc - e.startCyc, e.lat);
        lastHiA = e.hi; lastLoA = e.lo; lastDbzA = e.dbz;
      end
    end
  end

  always @(negedge clk) begin
    expT e;
    if (doneC) begin
      if (qC.size() == 0) check("C.unexpectedDone", 1, 0);
      else begin
        e = qC.pop_front();
        check("C.hi", hiC, e.hi);
        check("C.lo", loC, e.lo);
        check("C.dbz", dbzC, e.dbz);
        check("C.latency", cyc - e.startCyc, e.lat);
        lastHiC = e.hi; lastLoC = e.lo; lastDbzC = e.dbz;
      end
    end
  end

  always @(negedge clk) begin
    expT e;
    if (doneB) begin
      if (qB.size() == 0) check("B.unexpectedDone", 1, 0);
      else begin
        e = qB.pop_front();
        check("B.hi", hiB, e.hi);
        check("B.lo", loB, e.lo);
        check("B.dbz", dbzB, e.dbz);
        check("B.latency", cyc - e.startCyc, e.lat);
      end
    end
  end

  // called and returning at posedge+1
  task automatic issueAC(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    expT e;
    int unsigned n = 0;
    while (busyA && n < 200) begin @(posedge clk); #1; n++; end
    check("AC.idleBeforeStart", busyA, 0);
    op = o; a = x; b = y; start = 1'b1;
    e = model(32, 1'b1, o, x, y); e.startCyc = cyc; qA.push_back(e);
    e = model(32, 1'b0, o, x, y); e.startCyc = cyc; qC.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issueB(logic [1:0] o, logic [7:0] x, logic [7:0] y);
    expT e;
    int unsigned n = 0;
    while (busyB && n < 100) begin @(posedge clk); #1; n++; end
    check("B.idleBeforeStart", busyB, 0);
    opB = o; aB = x; bB = y; startB = 1'b1;
    e = model(8, 1'b1, o, {24'd0, x}, {24'd0, y}); e.startCyc = cyc; qB.push_back(e);
    @(posedge clk); #1;
    startB = 1'b0;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: return r[7:0];
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    int unsigned n;
    // reset, with start held high to show reset wins
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("A.rst.busy", busyA, 0);
    check("A.rst.done", doneA, 0);
    check("A.rst.hi", hiA, 0);
    check("A.rst.lo", loA, 0);
    check("A.rst.dbz", dbzA, 0);
    check("C.rst.busy", busyC, 0);
    check("B.rst.busy", busyB, 0);
    check("B.rst.hi", hiB, 0);
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1; rstB = 1'b1;
    @(posedge clk); #1;

    // MULTU 0xFFFFFFFF * 2 with busy profile
    issueAC(2'b00, 32'hFFFFFFFF, 32'd2);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      check("A.busyProfile", busyA, (i <= 33) ? 1 : 0);
    end
    @(posedge clk); #1;

    // flush in CALC: no done, HI/LO untouched
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("A.flush.busy", busyA, 0);
    check("A.flush.hi", hiA, 32'h1);
    check("A.flush.lo", loA, 32'hFFFFFFFE);
    check("C.flush.lo", loC, 32'hFFFFFFFE);
    @(posedge clk); #1;

    // start while busy is ignored
    issueAC(2'b00, 32'd3, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    issueAC(2'b01, 32'hFFFFFFFD, 32'd5);
    issueAC(2'b11, 32'hFFFFFFF9, 32'd2);
    issueAC(2'b10, 32'd100, 32'd7);
    issueAC(2'b10, 32'h1234, 32'd0);
    issueAC(2'b00, 32'd3, 32'd3);
    issueAC(2'b11, 32'h80000000, 32'hFFFFFFFF);

    // start and flush together in IDLE: dropped
    n = 0;
    while (busyA && n < 100) begin @(posedge clk); #1; n++; end
    op = 2'b00; a = 32'd7; b = 32'd7; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("A.flushStart.busy", busyA, 0);
    @(posedge clk); #1;

    // flush during the divide-by-zero FIN cycle
    op = 2'b10; a = 32'hAAAA; b = 32'd0; start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("A.finFlush.done", doneA, 0);
    check("A.finFlush.hi", hiA, lastHiA);
    check("A.finFlush.dbz", dbzA, lastDbzA);
    check("C.finFlush.lo", loC, lastLoC);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("A.finFlush.idle", busyA, 0);
    check("A.finFlush.lo", loA, lastLoA);
    check("C.finFlush.hi", hiC, lastHiC);
    check("C.finFlush.dbz", dbzC, lastDbzC);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o = 2'($urandom_range(0, 3));
      logic [31:0] y = pick32();
      if ($urandom_range(0, 9) == 0) y = 32'd0;
      issueAC(o, pick32(), y);
    end
    n = 0;
    while ((qA.size() != 0 || qC.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    check("A.drain", qA.size(), 0);
    check("C.drain", qC.size(), 0);

    // 8-bit instance
    issueB(2'b11, 8'h80, 8'hFF);
    issueB(2'b11, 8'hF9, 8'h02);
    issueB(2'b10, 8'h34, 8'h00);
    for (int i = 0; i < 30; i++) begin
      logic [1:0] o = 2'($urandom_range(0, 3));
      issueB(o, pick8(), pick8());
    end
    issueB(2'b01, 8'h80, 8'h80);
    n = 0;
    while (qB.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("B.drain", qB.size(), 0);

    // reset in mid-CALC aborts with no done
    opB = 2'b11; aB = 8'h50; bB = 8'h03; startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("B.midCalc.busy", busyB, 1);
    check("B.preRst.lo", loB, 8'h00);
    rstB = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("B.rstMid.busy", busyB, 0);
    check("B.rstMid.done", doneB, 0);
    check("B.rstMid.hi", hiB, 0);
    check("B.rstMid.lo", loB, 0);
    check("B.rstMid.dbz", dbzB, 0);
    @(posedge clk); #1;
    rstB = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("B.afterRst.busy", busyB, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
